// File: rtl/jtag_user_regbank.sv
// Bank of NREGS configuration registers behind a BSCAN user instruction/data path.
// All BSCAN signals are oversampled on CLK25; read-back, length check, write protect and soft reset.
module jtag_user_regbank #(
   parameter int                        NREGS      = 8,
   parameter int                        DATA_W     = 8,
   parameter int                        IR_W       = 4,
   parameter logic [NREGS*DATA_W-1:0]   DEF_VALUES = '0,
   parameter logic [NREGS-1:0]          WPROT      = '0
) (
   input  logic                       CLK25,
   input  logic                       RST_B,
   input  logic                       DRCK,
   input  logic                       SEL_IR,
   input  logic                       SEL_DR,
   input  logic                       SHIFT,
   input  logic                       UPDATE,
   input  logic                       TDI,
   output logic                       TDO,
   output logic [NREGS-1:0]           FSEL,
   output logic [NREGS*DATA_W-1:0]    REG_Q,
   output logic [NREGS-1:0]           UPD_STB,
   output logic                       LEN_ERR
);

   localparam int SW    = (DATA_W > IR_W) ? DATA_W : IR_W;
   localparam int CNT_W = $clog2(DATA_W + 2);
   localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);
   localparam logic [IR_W-1:0]  IR_NREGS = IR_W'(NREGS);

   typedef enum logic [1:0] {IDLE, SH_IR, SH_DR, UPD} state_t;

   // Bit order of the synchroniser bundle: {DRCK, SEL_IR, SEL_DR, SHIFT, UPDATE, TDI}
   logic [5:0]                    sync1_q, sync2_q;
   logic                          drck_d3_q, upd_d3_q;
   state_t                        state_q;
   logic [SW-1:0]                 shadow_q;
   logic [SW-1:0]                 shadow_sh;
   logic [CNT_W-1:0]              cnt_q;
   logic                          ir_mode_q;
   logic                          bypass_q;
   logic [IDX_W-1:0]              sel_idx_q;
   logic [NREGS-1:0]              fsel_q;
   logic [NREGS-1:0][DATA_W-1:0]  regs_q;
   logic [NREGS-1:0]              upd_stb_q;
   logic                          len_err_q;
   logic                          tdo_q;
   logic [IR_W-1:0]               ir_new;

   logic drck_s, sel_ir_s, sel_dr_s, shift_s, upd_s, tdi_s;
   logic drck_rise, upd_rise;

   assign drck_s    = sync2_q[5];
   assign sel_ir_s  = sync2_q[4];
   assign sel_dr_s  = sync2_q[3];
   assign shift_s   = sync2_q[2];
   assign upd_s     = sync2_q[1];
   assign tdi_s     = sync2_q[0];
   assign drck_rise = drck_s & ~drck_d3_q;
   assign upd_rise  = upd_s & ~upd_d3_q;
   assign ir_new    = shadow_q[IR_W-1:0];

   // TDI enters at the MSB of whichever chain is active (IR, DR, or 1-bit bypass).
   always_comb begin
      shadow_sh = shadow_q >> 1;
      if (ir_mode_q)
         shadow_sh[IR_W-1] = tdi_s;
      else if (bypass_q)
         shadow_sh[0] = tdi_s;
      else
         shadow_sh[DATA_W-1] = tdi_s;
   end

   always_ff @(posedge CLK25 or negedge RST_B) begin
      if (!RST_B) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         drck_d3_q <= 1'b0;
         upd_d3_q  <= 1'b0;
         state_q   <= IDLE;
         shadow_q  <= '0;
         cnt_q     <= '0;
         ir_mode_q <= 1'b0;
         bypass_q  <= 1'b1;
         sel_idx_q <= '0;
         fsel_q    <= '0;
         regs_q    <= DEF_VALUES;
         upd_stb_q <= '0;
         len_err_q <= 1'b0;
         tdo_q     <= 1'b0;
      end else begin
         sync1_q   <= {DRCK, SEL_IR, SEL_DR, SHIFT, UPDATE, TDI};
         sync2_q   <= sync1_q;
         drck_d3_q <= drck_s;
         upd_d3_q  <= upd_s;
         upd_stb_q <= '0;
         tdo_q     <= shadow_q[0];

         if (!sel_ir_s && !sel_dr_s) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (shift_s && sel_ir_s) begin
                     state_q   <= SH_IR;
                     ir_mode_q <= 1'b1;
                     bypass_q  <= 1'b0;
                     shadow_q  <= SW'(2'b01);
                     cnt_q     <= '0;
                  end else if (shift_s && sel_dr_s) begin
                     state_q   <= SH_DR;
                     ir_mode_q <= 1'b0;
                     cnt_q     <= '0;
                     if (fsel_q == '0) begin
                        bypass_q <= 1'b1;
                        shadow_q <= '0;
                     end else begin
                        bypass_q <= 1'b0;
                        shadow_q <= SW'(regs_q[sel_idx_q]);
                     end
                  end
               end
               SH_IR, SH_DR: begin
                  // A DRCK edge in the same cycle as UPDATE is shifted before the update acts.
                  if (drck_rise) begin
                     shadow_q <= shadow_sh;
                     if (cnt_q != CNT_SAT)
                        cnt_q <= cnt_q + 1'b1;
                  end
                  if (upd_rise)
                     state_q <= UPD;
               end
               UPD: begin
                  state_q <= IDLE;
                  if (ir_mode_q) begin
                     if (ir_new < IR_NREGS) begin
                        fsel_q    <= NREGS'(1) << ir_new;
                        sel_idx_q <= ir_new[IDX_W-1:0];
                     end else if (&ir_new) begin
                        regs_q    <= DEF_VALUES;
                        len_err_q <= 1'b0;
                        upd_stb_q <= '1;
                        fsel_q    <= '0;
                     end else begin
                        fsel_q <= '0;
                     end
                  end else if (fsel_q != '0) begin
                     if (cnt_q != CNT_FULL) begin
                        len_err_q <= 1'b1;
                     end else if (!WPROT[sel_idx_q]) begin
                        regs_q[sel_idx_q] <= shadow_q[DATA_W-1:0];
                        upd_stb_q         <= NREGS'(1) << sel_idx_q;
                        len_err_q         <= 1'b0;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign TDO     = tdo_q;
   assign FSEL    = fsel_q;
   assign REG_Q   = regs_q;
   assign UPD_STB = upd_stb_q;
   assign LEN_ERR = len_err_q;

endmodule

// File: doc/jtag_user_regbank.md
Name: jtag_user_regbank

Overview:
- Parametrised successor to the fixed per-function JTAG user register set: NREGS identical DATA_W-bit configuration registers behind one JTAG instruction/data path.
- Fully synchronous to CLK25: BSCAN signals (DRCK, SEL, SHIFT, UPDATE, TDI) are oversampled, not used as clocks.
- Adds over the current register set: read-back of the live value during every DR shift, shift-length checking with a sticky error, per-register write protect, and a soft-reset-to-defaults opcode.
- Sits between the BSCAN primitive and the CFEB configuration consumers (L1A delay, pre-block-end, comparator mode/time, buckeye mask, etc.).

Parameters:
- NREGS, 8, number of user registers; must be ≤ 2^IR_W − 2.
- DATA_W, 8, width of each user register; must be ≥ 2.
- IR_W, 4, instruction register width.
- DEF_VALUES, 0, NREGS*DATA_W default vector; register k is bits [k*DATA_W +: DATA_W].
- WPROT, 0, NREGS-bit mask; 1 = register is read-only over JTAG.

Ports:
- CLK25  input  1  system clock.
- RST_B  input  1  asynchronous active-low reset.
- DRCK  input  1  BSCAN data-register clock, asynchronous; treated as data.
- SEL_IR  input  1  instruction chain selected.
- SEL_DR  input  1  data chain selected.
- SHIFT  input  1  TAP Shift state.
- UPDATE  input  1  TAP Update state.
- TDI  input  1  serial data in.
- TDO  output  1  serial data out.
- FSEL  output  NREGS  one-hot decoded function; all zero = NoOp/bypass.
- REG_Q  output  NREGS*DATA_W  parallel register contents.
- UPD_STB  output  NREGS  one-cycle pulse when register k is written.
- LEN_ERR  output  1  sticky shift-length error.

Behaviour:
- Sync: DRCK, SEL_IR, SEL_DR, SHIFT, UPDATE and TDI each pass through a 2-FF synchroniser. Edge detects use a third stage. DRCK high and low times must each be ≥ 3 CLK25 periods.
- Reset (RST_B low, async): REG_Q = DEF_VALUES; FSEL = 0; ir = 0; TDO = 0; UPD_STB = 0; LEN_ERR = 0; bit count = 0; FSM = IDLE.
- FSM states: IDLE, SH_IR, SH_DR, UPD.
  - IDLE→SH_IR: synced SHIFT & SEL_IR.
  - IDLE→SH_DR: synced SHIFT & SEL_DR.
  - SH_*→UPD: synced UPDATE rising edge.
  - UPD→IDLE: next cycle.
  - SH_* with SHIFT dropped and no UPDATE: stays in SH_* (Exit/Pause); resumes on the next DRCK edges.
  - Loss of both SEL from any state→IDLE without update.
- Entry to SH_DR (capture):
  - shadow[DATA_W-1:0] ← REG_Q of the selected register.
  - When FSEL = 0, shadow is 1 bit = 0 (bypass).
  - bit count ← 0.
- Entry to SH_IR: shadow[IR_W-1:0] ← {IR_W-2 zeros, 2'b01}; bit count ← 0.
- Each synced DRCK rising edge while in SH_*:
  - shadow shifts right, with TDI entering at the MSB of the active length.
  - bit count increments, saturating at DATA_W+1.
- TDO = shadow[0], registered; it changes one CLK25 cycle after each shift.
- UPD from SH_IR:
  - ir ← shadow[IR_W-1:0].
  - If ir < NREGS: FSEL = one-hot(ir).
  - If ir = all-ones (soft reset): REG_Q ← DEF_VALUES, LEN_ERR ← 0, UPD_STB = all ones for one cycle, FSEL ← 0.
  - Otherwise: FSEL ← 0.
  - IR length is not checked.
- UPD from SH_DR with FSEL = one-hot(k):
  - Count = DATA_W and WPROT[k] = 0: REG_Q[k] ← shadow; UPD_STB[k] = 1 in the cycle after UPD is entered; LEN_ERR ← 0.
  - Count ≠ DATA_W: no write; LEN_ERR ← 1.
  - WPROT[k] = 1: no write, no error; read-back still works.
- UPD from SH_DR with FSEL = 0: nothing happens.
- LEN_ERR clears only on reset, soft reset, or a good write.
- Simultaneous events:
  - DRCK edge and UPDATE edge in the same cycle: the shift is taken first, then UPD.
  - RST_B asserted mid-shift: shadow is discarded and no write occurs.

Test Plan:
- Reset with DEF_VALUES = {8'h09, 8'h01, …} → REG_Q matches; FSEL = 0; LEN_ERR = 0; TDO = 0.
- IR shift 4'h2 then DR shift 8'hA5 (8 bits) → REG_Q[2] = 8'hA5; UPD_STB[2] single pulse; TDO stream = previous value 8'h00, LSB first.
- Select reg 2, DR shift 7 bits → REG_Q[2] unchanged; LEN_ERR = 1. Then shift 8'h3C → written; LEN_ERR = 0.
- WPROT[3] = 1, shift 8'hFF into reg 3 → unchanged; no UPD_STB; TDO returns the default value.
- Write regs 0–7, then IR 4'hF → all REG_Q = DEF_VALUES; UPD_STB = 8'hFF for one cycle.
- IR 4'h9 (> NREGS), shift 10 bits → FSEL = 0; TDO = TDI delayed by one DRCK (bypass); no register changes; assert RST_B mid-DR-shift → defaults, FSM = IDLE.
